control_sequencer: RTL and testbench
====================================

# control_sequencer

Multi-cycle fetch/decode/execute controller that drives the register-select codes of the CPU datapath. It sequences instruction fetch through the datapath's memory-address register and decodes 16-bit instruction words. It drives every `Src*` select, the immediate and the ALU operation, and performs a valid/ready handshake with memory. It sits between the memory port and the datapath, and its outputs connect directly to the datapath's select inputs.

## Interface
- No parameters; select codes are the shared `SELECT_*` defines (5-bit).
- Clk  in  1  clock
- Rst  in  1  reset, asynchronous, active-high
- MemData  in  16  read data from memory; instruction word during fetch
- MemReady  in  1  memory completes the pending read/write in this cycle
- SrcIP, SrcMemAddr, SrcMemData, SrcSP, SrcFlags, SrcA, SrcB  out  5 each  datapath select codes
- Imm  out  16  `{4'h0, IR[11:0]}`, driven continuously
- AluOp  out  4  `IR[3:0]`, driven continuously
- MemRead  out  1  read request, held until MemReady
- MemWrite  out  1  write request, held until MemReady
- Halted  out  1  sequencer is in HALT
- IllegalOp  out  1  undefined opcode trapped (only with the macro; otherwise tied 0)

## Operation
- IR is a 16-bit instruction register; the opcode is `IR[15:12]`.
- Every select defaults to `SELECT_NONE`. The states below list only the asserted selects, which are combinational from state, IR and MemReady.
- IDLE: entered on reset. No selects asserted. Next state is FETCH.
- FETCH: SrcMemAddr=`SELECT_IP`. Next state is FWAIT.
- FWAIT: MemRead=1.
  - On MemReady: IR<=MemData, SrcIP=`SELECT_INC`, go to DECODE.
  - Otherwise stay in FWAIT.
- DECODE: action depends on opcode.
  - 0 NOP: go to FETCH.
  - 1 LDA and 2 LDB: SrcMemAddr=`SELECT_SP`, go to MRD.
  - 3 PUSHI: SrcMemData=`SELECT_IMM`, SrcMemAddr=`SELECT_SP`, go to MWR.
  - 4 ALU: SrcA=`SELECT_ALU`, SrcFlags=`SELECT_ALU`, go to FETCH.
  - 6 POPA: SrcSP=`SELECT_INC`, go to POPADR.
  - F HALT: go to HALT.
  - Others: see Configuration.
- POPADR: SrcMemAddr=`SELECT_SP`, which loads the already-incremented SP. Next state is MRD.
- MRD: MemRead=1.
  - On MemReady: SrcB=`SELECT_MEM` for LDB; SrcA=`SELECT_MEM` for LDA and POPA. Go to FETCH.
- MWR: MemWrite=1.
  - On MemReady: SrcSP=`SELECT_DEC`, go to FETCH.
- HALT: Halted=1, all selects NONE. Only Rst leaves this state.
- Stack convention: SP points to the next free slot. Push writes first, then decrements SP. Pop increments SP first, then reads.

## Timing
- Reset values:
  - Outputs: all selects `SELECT_NONE`, MemRead=0, MemWrite=0, Halted=0, IllegalOp=0.
  - Internal: IR=0, so Imm=0 and AluOp=0.
- Reset is asynchronous at any point, including mid-FWAIT, MRD or MWR. The state goes to IDLE at once, and MemRead/MemWrite drop without waiting for MemReady.
- Handshake:
  - A request is held for as many cycles as MemReady stays low.
  - The transfer completes in the first cycle in which request and MemReady are both high.
  - MemReady is ignored outside FWAIT, MRD and MWR.
- Latency with MemReady always high:
  - NOP, ALU, illegal-as-NOP: 3 cycles.
  - LDA, LDB, PUSHI: 4 cycles.
  - POPA: 5 cycles.
- Each additional cycle of low MemReady adds exactly one cycle.
- The first FETCH after reset is the second cycle after Rst deasserts and addresses IP=0.
- SrcIP=`SELECT_INC` is asserted for exactly one cycle per fetched instruction, including HALT.

## Configuration
- `SEQ_ILLEGAL_TRAP_EN` defined: opcodes 5, 7–E in DECODE go to HALT.
  - IllegalOp goes to 1 along with Halted and holds until Rst.
- `SEQ_ILLEGAL_TRAP_EN` undefined: those opcodes execute as NOP (3 cycles) and IllegalOp is constant 0.

## Test plan
- NOP stream: Rst pulse, MemData=0x0000, MemReady=1 → after IDLE, SrcMemAddr=IP, MemRead, SrcIP=INC repeat with period 3; Halted=0.
- PUSHI 0x3123 → Imm=0x0123 and SrcMemData=IMM in DECODE. MWR asserts MemWrite=1; with MemReady low for 2 cycles, MemWrite holds 3 cycles, then SrcSP=DEC for one cycle.
- Fetch stall: MemReady=0 for 4 cycles in FWAIT → MemRead=1 for 5 cycles; IR and SrcIP unchanged until the ready cycle.
- ALU 0x4005 → AluOp=5; SrcA=ALU and SrcFlags=ALU in one DECODE cycle; back to FETCH on the next cycle.
- POPA 0x6000 then HALT 0xF000 → SrcSP=INC, then SrcMemAddr=SP, then SrcA=MEM on ready. HALT then gives Halted=1 with no further MemRead; Rst clears Halted.
- Opcode 0x7000 → with `SEQ_ILLEGAL_TRAP_EN`: Halted=1 and IllegalOp=1. Without it: NOP timing, IllegalOp=0. Rst asserted mid-MRD drops MemRead immediately.

Source files
------------

// File: rtl/control_sequencer.sv
// -----------------------------------------------------------------------------
// control_sequencer
//
// Multi-cycle fetch/decode/execute controller for the CPU datapath. It
// fetches 16-bit instruction words through the datapath's memory-address
// register, decodes them, and drives the datapath select codes, the
// immediate and the ALU operation. Memory is accessed with a valid/ready
// handshake.
//
// Optional feature macro: SEQ_ILLEGAL_TRAP_EN
//   defined   : undefined opcodes (5, 7..E) halt the sequencer and raise IllegalOp
//   undefined : undefined opcodes execute as NOP, IllegalOp is tied 0
//
// Ports
//   Clk         in   1   clock
//   Rst         in   1   asynchronous, active-high reset
//   MemData     in  16   memory read data (instruction word during fetch)
//   MemReady    in   1   memory completes the pending read/write this cycle
//   SrcIP .. SrcB out 5  datapath select codes (SELECT_* encodings)
//   Imm         out 16   {4'h0, IR[11:0]}
//   AluOp       out  4   IR[3:0]
//   MemRead     out  1   read request, held until MemReady
//   MemWrite    out  1   write request, held until MemReady
//   Halted      out  1   sequencer is in HALT
//   IllegalOp   out  1   undefined opcode trapped
//
// Handshake: a request (MemRead/MemWrite) is a combinational function of the
// state and stays high while MemReady is low; the transfer completes in the
// first cycle where request and MemReady are both high. MemReady is ignored
// in every other state.
// -----------------------------------------------------------------------------

`ifndef SELECT_NONE
`define SELECT_NONE 5'd0
`endif
`ifndef SELECT_IP
`define SELECT_IP   5'd1
`endif
`ifndef SELECT_INC
`define SELECT_INC  5'd2
`endif
`ifndef SELECT_DEC
`define SELECT_DEC  5'd3
`endif
`ifndef SELECT_SP
`define SELECT_SP   5'd4
`endif
`ifndef SELECT_IMM
`define SELECT_IMM  5'd5
`endif
`ifndef SELECT_ALU
`define SELECT_ALU  5'd6
`endif
`ifndef SELECT_MEM
`define SELECT_MEM  5'd7
`endif

module control_sequencer (
   input  logic        Clk,
   input  logic        Rst,
   input  logic [15:0] MemData,
   input  logic        MemReady,
   output logic [4:0]  SrcIP,
   output logic [4:0]  SrcMemAddr,
   output logic [4:0]  SrcMemData,
   output logic [4:0]  SrcSP,
   output logic [4:0]  SrcFlags,
   output logic [4:0]  SrcA,
   output logic [4:0]  SrcB,
   output logic [15:0] Imm,
   output logic [3:0]  AluOp,
   output logic        MemRead,
   output logic        MemWrite,
   output logic        Halted,
   output logic        IllegalOp
);

   typedef enum logic [3:0] {
      S_IDLE   = 4'd0,
      S_FETCH  = 4'd1,
      S_FWAIT  = 4'd2,
      S_DECODE = 4'd3,
      S_POPADR = 4'd4,
      S_MRD    = 4'd5,
      S_MWR    = 4'd6,
      S_HALT   = 4'd7
   } state_t;

   localparam logic [3:0] OP_NOP   = 4'h0;
   localparam logic [3:0] OP_LDA   = 4'h1;
   localparam logic [3:0] OP_LDB   = 4'h2;
   localparam logic [3:0] OP_PUSHI = 4'h3;
   localparam logic [3:0] OP_ALU   = 4'h4;
   localparam logic [3:0] OP_POPA  = 4'h6;
   localparam logic [3:0] OP_HALT  = 4'hF;

   state_t      r_state;
   logic [15:0] r_ir;
   logic [3:0]  w_opcode;

`ifdef SEQ_ILLEGAL_TRAP_EN
   logic        r_illegal;
`endif

   assign w_opcode = r_ir[15:12];
   assign Imm      = {4'h0, r_ir[11:0]};
   assign AluOp    = r_ir[3:0];
   assign Halted   = (r_state == S_HALT);

`ifdef SEQ_ILLEGAL_TRAP_EN
   assign IllegalOp = r_illegal;
`else
   assign IllegalOp = 1'b0;
`endif

   // State register and IR. The async reset drops the requests at once
   // because MemRead/MemWrite are decoded from r_state.
   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) begin
         r_state   <= S_IDLE;
         r_ir      <= 16'h0000;
`ifdef SEQ_ILLEGAL_TRAP_EN
         r_illegal <= 1'b0;
`endif
      end else begin
         case (r_state)
            S_IDLE:  r_state <= S_FETCH;
            S_FETCH: r_state <= S_FWAIT;
            S_FWAIT: begin
               if (MemReady) begin
                  r_ir    <= MemData;
                  r_state <= S_DECODE;
               end
            end
            S_DECODE: begin
               case (w_opcode)
                  OP_NOP:         r_state <= S_FETCH;
                  OP_LDA, OP_LDB: r_state <= S_MRD;
                  OP_PUSHI:       r_state <= S_MWR;
                  OP_ALU:         r_state <= S_FETCH;
                  OP_POPA:        r_state <= S_POPADR;
                  OP_HALT:        r_state <= S_HALT;
                  default: begin
`ifdef SEQ_ILLEGAL_TRAP_EN
                     // Set together with the HALT entry so both flags rise in the same cycle.
                     r_illegal <= 1'b1;
                     r_state   <= S_HALT;
`else
                     r_state   <= S_FETCH;
`endif
                  end
               endcase
            end
            S_POPADR: r_state <= S_MRD;
            S_MRD:    if (MemReady) r_state <= S_FETCH;
            S_MWR:    if (MemReady) r_state <= S_FETCH;
            S_HALT:   r_state <= S_HALT;
            default:  r_state <= S_IDLE;
         endcase
      end
   end

   // Select codes and memory requests, decoded from state, IR and MemReady.
   always_comb begin
      SrcIP      = `SELECT_NONE;
      SrcMemAddr = `SELECT_NONE;
      SrcMemData = `SELECT_NONE;
      SrcSP      = `SELECT_NONE;
      SrcFlags   = `SELECT_NONE;
      SrcA       = `SELECT_NONE;
      SrcB       = `SELECT_NONE;
      MemRead    = 1'b0;
      MemWrite   = 1'b0;
      case (r_state)
         S_FETCH: SrcMemAddr = `SELECT_IP;
         S_FWAIT: begin
            MemRead = 1'b1;
            if (MemReady) SrcIP = `SELECT_INC;
         end
         S_DECODE: begin
            case (w_opcode)
               OP_LDA, OP_LDB: SrcMemAddr = `SELECT_SP;
               OP_PUSHI: begin
                  SrcMemData = `SELECT_IMM;
                  SrcMemAddr = `SELECT_SP;
               end
               OP_ALU: begin
                  SrcA     = `SELECT_ALU;
                  SrcFlags = `SELECT_ALU;
               end
               // Pop pre-increments SP; the address is taken in POPADR.
               OP_POPA: SrcSP = `SELECT_INC;
               default: ;
            endcase
         end
         S_POPADR: SrcMemAddr = `SELECT_SP;
         S_MRD: begin
            MemRead = 1'b1;
            if (MemReady) begin
               if (w_opcode == OP_LDB) SrcB = `SELECT_MEM;
               else                    SrcA = `SELECT_MEM;
            end
         end
         S_MWR: begin
            // Push writes first, then post-decrements SP.
            MemWrite = 1'b1;
            if (MemReady) SrcSP = `SELECT_DEC;
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_control_sequencer.sv
// -----------------------------------------------------------------------------
// tb_control_sequencer
//
// Per-cycle vector table for control_sequencer. Each record holds the inputs
// for one clock cycle and the full expected output set for that cycle. The
// expected record is queued when the inputs are driven and popped/compared
// half a cycle later, away from the active edge.
// -----------------------------------------------------------------------------
module tb_control_sequencer;

  localparam logic [4:0] S_N   = 5'd0;
  localparam logic [4:0] S_IP  = 5'd1;
  localparam logic [4:0] S_INC = 5'd2;
  localparam logic [4:0] S_DEC = 5'd3;
  localparam logic [4:0] S_SP  = 5'd4;
  localparam logic [4:0] S_IMM = 5'd5;
  localparam logic [4:0] S_ALU = 5'd6;
  localparam logic [4:0] S_MEM = 5'd7;

  typedef struct packed {
    logic [4:0]  ip;
    logic [4:0]  maddr;
    logic [4:0]  mdata;
    logic [4:0]  sp;
    logic [4:0]  flags;
    logic [4:0]  a;
    logic [4:0]  b;
    logic [15:0] imm;
    logic [3:0]  aluop;
    logic        rd;
    logic        wr;
    logic        halt;
    logic        ill;
  } out_t;

  typedef struct {
    string       tag;
    logic        rst;
    logic [15:0] md;
    logic        rdy;
    out_t        exp;
  } vec_t;

  // ---------------- clock / reset / DUT ----------------
  logic        Clk = 1'b0;
  logic        Rst = 1'b1;
  logic [15:0] MemData = 16'h0000;
  logic        MemReady = 1'b0;
  logic [4:0]  SrcIP, SrcMemAddr, SrcMemData, SrcSP, SrcFlags, SrcA, SrcB;
  logic [15:0] Imm;
  logic [3:0]  AluOp;
  logic        MemRead, MemWrite, Halted, IllegalOp;

  always #5 Clk = ~Clk;

  control_sequencer dut (
    .Clk(Clk), .Rst(Rst), .MemData(MemData), .MemReady(MemReady),
    .SrcIP(SrcIP), .SrcMemAddr(SrcMemAddr), .SrcMemData(SrcMemData),
    .SrcSP(SrcSP), .SrcFlags(SrcFlags), .SrcA(SrcA), .SrcB(SrcB),
    .Imm(Imm), .AluOp(AluOp), .MemRead(MemRead), .MemWrite(MemWrite),
    .Halted(Halted), .IllegalOp(IllegalOp)
  );

  // ---------------- table building ----------------
  vec_t        vecs[$];
  out_t        exp_q[$];
  logic [15:0] ir;
  logic        ill_flag;
  int          errors = 0;
  int          checks = 0;

  function automatic out_t bo();
    out_t o;
    o       = '0;
    o.imm   = {4'h0, ir[11:0]};
    o.aluop = ir[3:0];
    o.ill   = ill_flag;
    return o;
  endfunction

  task automatic row(input string tag, input logic rst, input logic [15:0] md,
                     input logic rdy, input out_t o);
    vec_t v;
    v.tag = tag; v.rst = rst; v.md = md; v.rdy = rdy; v.exp = o;
    vecs.push_back(v);
  endtask

  task automatic reset_row();
    out_t o;
    ir = 16'h0000; ill_flag = 1'b0;
    o = bo();
    row("reset", 1'b1, 16'hFFFF, 1'b1, o);
  endtask

  task automatic idle_row();
    out_t o;
    o = bo();
    row("idle", 1'b0, 16'h0000, 1'b1, o);
  endtask

  task automatic fetch(input logic [15:0] instr, input int stall);
    out_t o;
    o = bo(); o.maddr = S_IP;
    row("fetch", 1'b0, 16'hBEEF, 1'b1, o);
    for (int k = 0; k < stall; k++) begin
      o = bo(); o.rd = 1'b1;
      row("fwait_stall", 1'b0, 16'hBEEF, 1'b0, o);
    end
    o = bo(); o.rd = 1'b1; o.ip = S_INC;
    row("fwait_ready", 1'b0, instr, 1'b1, o);
    ir = instr;
  endtask

  task automatic build_table();
    out_t o;
    reset_row();
    reset_row();
    idle_row();
    for (int k = 0; k < 2; k++) begin
      fetch(16'h0000, 0);
      o = bo(); row("nop_decode", 1'b0, 16'h0000, 1'b0, o);
    end
    fetch(16'h4005, 4);
    o = bo(); o.a = S_ALU; o.flags = S_ALU;
    row("alu_decode", 1'b0, 16'h0000, 1'b0, o);
    fetch(16'h3123, 0);
    o = bo(); o.mdata = S_IMM; o.maddr = S_SP;
    row("pushi_decode", 1'b0, 16'h0000, 1'b1, o);
    for (int k = 0; k < 2; k++) begin
      o = bo(); o.wr = 1'b1;
      row("mwr_stall", 1'b0, 16'h0000, 1'b0, o);
    end
    o = bo(); o.wr = 1'b1; o.sp = S_DEC;
    row("mwr_ready", 1'b0, 16'h0000, 1'b1, o);
    fetch(16'h1abc, 0);
    o = bo(); o.maddr = S_SP;
    row("lda_decode", 1'b0, 16'h0000, 1'b1, o);
    o = bo(); o.rd = 1'b1; o.a = S_MEM;
    row("lda_mrd", 1'b0, 16'h5555, 1'b1, o);
    fetch(16'h2007, 0);
    o = bo(); o.maddr = S_SP;
    row("ldb_decode", 1'b0, 16'h0000, 1'b0, o);
    o = bo(); o.rd = 1'b1;
    row("ldb_mrd_stall", 1'b0, 16'h0000, 1'b0, o);
    o = bo(); o.rd = 1'b1; o.b = S_MEM;
    row("ldb_mrd_ready", 1'b0, 16'h0000, 1'b1, o);
    fetch(16'h6000, 0);
    o = bo(); o.sp = S_INC;
    row("popa_decode", 1'b0, 16'h0000, 1'b1, o);
    o = bo(); o.maddr = S_SP;
    row("popa_adr", 1'b0, 16'h0000, 1'b1, o);
    o = bo(); o.rd = 1'b1; o.a = S_MEM;
    row("popa_mrd", 1'b0, 16'h0000, 1'b1, o);
    fetch(16'h1000, 0);
    o = bo(); o.maddr = S_SP;
    row("lda2_decode", 1'b0, 16'h0000, 1'b0, o);
    o = bo(); o.rd = 1'b1;
    row("lda2_mrd_stall", 1'b0, 16'h0000, 1'b0, o);
    reset_row();
    idle_row();
    fetch(16'h7000, 0);
    o = bo();
    row("illegal_decode", 1'b0, 16'h0000, 1'b1, o);
`ifdef SEQ_ILLEGAL_TRAP_EN
    ill_flag = 1'b1;
    for (int k = 0; k < 2; k++) begin
      o = bo(); o.halt = 1'b1;
      row("illegal_halt", 1'b0, 16'h0000, 1'b1, o);
    end
    reset_row();
    idle_row();
`endif
    fetch(16'hF000, 0);
    o = bo();
    row("halt_decode", 1'b0, 16'h0000, 1'b1, o);
    for (int k = 0; k < 3; k++) begin
      o = bo(); o.halt = 1'b1;
      row("halted", 1'b0, 16'h0000, 1'b1, o);
    end
    reset_row();
    idle_row();
    o = bo(); o.maddr = S_IP;
    row("fetch_after_halt", 1'b0, 16'h0000, 1'b1, o);
  endtask

  // ---------------- scoreboard ----------------
  task automatic check_out(input string tag, input int idx);
    out_t act;
    out_t exp;
    act.ip = SrcIP; act.maddr = SrcMemAddr; act.mdata = SrcMemData;
    act.sp = SrcSP; act.flags = SrcFlags; act.a = SrcA; act.b = SrcB;
    act.imm = Imm; act.aluop = AluOp; act.rd = MemRead; act.wr = MemWrite;
    act.halt = Halted; act.ill = IllegalOp;
    exp = exp_q.pop_front();
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s (row %0d): got ip=%0d maddr=%0d mdata=%0d sp=%0d flags=%0d a=%0d b=%0d imm=%h alu=%h rd=%b wr=%b halt=%b ill=%b, required ip=%0d maddr=%0d mdata=%0d sp=%0d flags=%0d a=%0d b=%0d imm=%h alu=%h rd=%b wr=%b halt=%b ill=%b",
               tag, idx,
               act.ip, act.maddr, act.mdata, act.sp, act.flags, act.a, act.b,
               act.imm, act.aluop, act.rd, act.wr, act.halt, act.ill,
               exp.ip, exp.maddr, exp.mdata, exp.sp, exp.flags, exp.a, exp.b,
               exp.imm, exp.aluop, exp.rd, exp.wr, exp.halt, exp.ill);
    end
  endtask

  // ---------------- driver ----------------
  initial begin
    out_t o;
    ir = 16'h0000;
    ill_flag = 1'b0;
    build_table();
    for (int i = 0; i < vecs.size(); i++) begin
      @(posedge Clk);
      #1;
      Rst      = vecs[i].rst;
      MemData  = vecs[i].md;
      MemReady = vecs[i].rdy;
      exp_q.push_back(vecs[i].exp);
      @(negedge Clk);
      check_out(vecs[i].tag, i);
    end

    @(posedge Clk);
    #1;
    Rst      = 1'b1;
    MemData  = 16'hA5A5;
    MemReady = 1'b1;
    ir = 16'h0000; ill_flag = 1'b0;
    #1;
    o = bo();
    exp_q.push_back(o);
    check_out("reset_state", -1);

    @(posedge Clk);
    #1;
    Rst      = 1'b0;
    MemReady = 1'b0;
    @(negedge Clk);
    o = bo();
    exp_q.push_back(o);
    check_out("wait_idle", -1);
    @(posedge Clk);
    #1;
    @(negedge Clk);
    o = bo(); o.maddr = S_IP;
    exp_q.push_back(o);
    check_out("wait_fetch", -1);
    for (int k = 0; k < 5; k++) begin
      @(posedge Clk);
      #1;
      MemData = 16'($urandom_range(0, 16'hFFFF));
      @(negedge Clk);
      o = bo(); o.rd = 1'b1;
      exp_q.push_back(o);
      check_out("expired_wait", k);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
